afifo_read_sched: RTL and testbench
===================================

Name: afifo_read_sched

Overview:
- Read-side scheduler for the 12-bit async FIFO; shares its single read port among NReq consumers.
- Each consumer requests a burst. The scheduler grants one consumer at a time in round-robin order and streams up to BurstLen words to it over a valid/ready handshake.
- Drives the FIFO pop strobe.
- Lives entirely in the rclk domain and sits between the FIFO read port and the consumer blocks.

Parameters:
- Width, 12, FIFO word width.
- NReq, 4, number of consumers (2..8).
- BurstLen, 8, maximum words per grant (1..256).
- StallMax, 16, consecutive empty cycles in BURST before the burst is truncated (1..255).

Ports:
- rclk  in  1  read-domain clock.
- dirclr  in  1  asynchronous active-high reset.
- fifo_r  out  1  FIFO pop strobe; combinational.
- fifo_rd  in  Width  FIFO head word (fall-through; valid while fifo_rempty=0).
- fifo_rempty  in  1  FIFO empty flag, already synchronous to rclk.
- req  in  NReq  per-consumer burst request, level.
- gnt  out  NReq  one-hot grant, registered.
- dout  out  Width  data to granted consumer.
- dvalid  out  1  dout valid.
- dready  in  NReq  per-consumer ready; only dready[sel] is observed.
- burst_done  out  1  one-cycle pulse: burst reached BurstLen words.
- burst_short  out  1  one-cycle pulse: burst ended early by req drop or stall timeout.

Behaviour:
- Reset is dirclr, asynchronous, active-high; clock is rclk.
- While dirclr=1:
  - state=IDLE, gnt=0, fifo_r=0, dvalid=0.
  - burst_done=0, burst_short=0.
  - word count=0, stall count=0, round-robin pointer=0, so consumer 0 has first priority.
- States are IDLE, BURST and END.
- IDLE:
  - gnt=0, dvalid=0, fifo_r=0.
  - If req!=0, select the first requester at or after the rr pointer, scanning upward with wrap.
  - On that cycle register gnt=onehot(sel), set rr pointer=(sel+1) mod NReq, clear counts, and go to BURST.
- BURST:
  - dout=fifo_rd; dvalid=!fifo_rempty; fifo_r=dvalid & dready[sel]. These are combinational, with no added latency beyond the FIFO.
  - A pop is a cycle with fifo_r=1. A pop increments word count and clears stall count.
  - A cycle with fifo_rempty=1 increments stall count, saturating.
  - Pop with count==BurstLen-1: go to END and pulse burst_done on the next cycle.
  - Otherwise, if req[sel]=0 and no pop this cycle: go to END and pulse burst_short.
  - Otherwise, if stall count reaches StallMax-1 while empty: go to END and pulse burst_short.
  - Priority when events coincide: completing pop > req drop > stall timeout.
  - A pop and a req drop in the same cycle: the pop is honoured; the burst ends only if it was the last word, else it ends on the next non-pop cycle.
- END:
  - Lasts one cycle: gnt=0, dvalid=0, fifo_r=0, and the done/short pulse is asserted.
  - Then go to IDLE. The minimum gap between consecutive grants is therefore 2 cycles (END, IDLE).
- Width rules:
  - Word counter is clog2(BurstLen+1) bits; stall counter is 8 bits.
  - rr pointer is clog2(NReq) bits, with explicit wrap at NReq (not a power-of-2 assumption).
- fifo_r is never 1 when fifo_rempty=1, when gnt=0, or during dirclr.
- Reset mid-burst drops the grant immediately, asynchronously. Words already popped are not replayed. No pulse is emitted.
- A consumer dropping req outside its grant has no effect. Requests are not latched.
- dready of non-granted consumers is ignored.

Test Plan:
- Reset, then req=4'b0001, with the FIFO preloaded with 0x000..0x00F and dready=1:
  - gnt=0001 one cycle after req.
  - 8 consecutive pops with dout 0x000..0x007.
  - burst_done pulses once, followed by a 2-cycle gap.
- req=4'b1111 held, with the FIFO always non-empty:
  - Grants go 0001, 0010, 0100, 1000, 0001, each 8 words.
  - No consumer is granted twice before all four have been served.
- Granted consumer 2 with dready toggling 1,0,1,0:
  - Pops occur only on ready cycles.
  - 8 words over 16 cycles; data is contiguous with no skips or duplicates.
- FIFO runs empty after 3 words with req held:
  - After 16 empty cycles, burst_short pulses and gnt clears.
  - Word count is 3; the next grant goes to the next requester.
- req[1] drops after 5 pops (dropping cycle has no pop):
  - END on the next cycle with burst_short=1.
  - Exactly 5 words are delivered.
  - A req drop coinciding with a pop still delivers that word.
- dirclr asserted mid-burst after 4 pops:
  - gnt=0 and fifo_r=0 within the same cycle, asynchronously.
  - After release, consumer 0 has priority and no pulse is emitted.

Source files
------------

// File: rtl/afifo_read_sched.sv
// Read-side scheduler for the async FIFO: shares the single read port among
// NReq consumers, granting one at a time in round-robin order and streaming
// up to BurstLen words per grant over a valid/ready handshake.
module afifo_read_sched #(
    parameter int Width    = 12,
    parameter int NReq     = 4,
    parameter int BurstLen = 8,
    parameter int StallMax = 16
) (
    input  logic              rclk,
    input  logic              dirclr,
    output logic              fifo_r,
    input  logic [Width-1:0]  fifo_rd,
    input  logic              fifo_rempty,
    input  logic [NReq-1:0]   req,
    output logic [NReq-1:0]   gnt,
    output logic [Width-1:0]  dout,
    output logic              dvalid,
    input  logic [NReq-1:0]   dready,
    output logic              burst_done,
    output logic              burst_short
);

    localparam int SelW = $clog2(NReq);
    localparam int CntW = $clog2(BurstLen + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_END   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [SelW-1:0]   sel_q, sel_d;
    logic [SelW-1:0]   rr_q, rr_d;
    logic [CntW-1:0]   word_q, word_d;
    logic [7:0]        stall_q, stall_d;
    logic [NReq-1:0]   gnt_q, gnt_d;
    logic              done_q, done_d;   // END flavour: 1 = full burst, 0 = truncated

    logic              arb_hit;
    logic [SelW-1:0]   arb_sel;
    logic              pop;
    logic              last_pop;
    logic              req_drop;
    logic              stall_to;

    // First requester at or after ptr, scanning upward with explicit wrap at
    // NReq so non-power-of-two consumer counts work.
    function automatic logic [SelW:0] rr_pick(input logic [NReq-1:0] r,
                                              input logic [SelW-1:0] ptr);
        logic            hit;
        logic [SelW-1:0] s;
        int              idx;
        hit = 1'b0;
        s   = '0;
        for (int k = 0; k < NReq; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NReq) idx = idx - NReq;
            if (!hit && r[idx[SelW-1:0]]) begin
                hit = 1'b1;
                s   = idx[SelW-1:0];
            end
        end
        return {hit, s};
    endfunction

    // Round-robin arbitration against the current pointer
    always_comb begin
        {arb_hit, arb_sel} = rr_pick(req, rr_q);
    end

    // Burst events; a pop needs a live head word and the granted consumer ready
    assign pop      = (state_q == S_BURST) & ~fifo_rempty & dready[sel_q] & ~dirclr;
    assign last_pop = pop && (word_q == CntW'(BurstLen - 1));
    assign req_drop = ~req[sel_q] & ~pop;
    assign stall_to = fifo_rempty && (stall_q >= 8'(StallMax - 1));

    // FSM state register
    always_ff @(posedge rclk or posedge dirclr) begin
        if (dirclr) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; a completing pop outranks a req drop, which outranks a stall timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (arb_hit) state_d = S_BURST;
            S_BURST: begin
                if (last_pop)      state_d = S_END;
                else if (req_drop) state_d = S_END;
                else if (stall_to) state_d = S_END;
            end
            S_END:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; data path is combinational from the FIFO head
    always_comb begin
        fifo_r      = 1'b0;
        dvalid      = 1'b0;
        burst_done  = 1'b0;
        burst_short = 1'b0;
        dout        = fifo_rd;
        case (state_q)
            S_BURST: begin
                dvalid = ~fifo_rempty;
                fifo_r = pop;
            end
            S_END: begin
                burst_done  = done_q;
                burst_short = ~done_q;
            end
            default: ;
        endcase
    end

    assign gnt = gnt_q;

    // Grant, pointer and counter next-state
    always_comb begin
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        word_d  = word_q;
        stall_d = stall_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE: begin
                if (arb_hit) begin
                    gnt_d   = NReq'(1) << arb_sel;
                    sel_d   = arb_sel;
                    rr_d    = (arb_sel == SelW'(NReq - 1)) ? '0 : arb_sel + 1'b1;
                    word_d  = '0;
                    stall_d = '0;
                end
            end
            S_BURST: begin
                if (pop) begin
                    word_d  = word_q + 1'b1;
                    stall_d = '0;
                end else if (fifo_rempty && stall_q != 8'hFF) begin
                    stall_d = stall_q + 8'd1;
                end
                if (state_d == S_END) begin
                    gnt_d  = '0;
                    done_d = last_pop;
                end
            end
            default: ;
        endcase
    end

    // Grant and counter registers; reset drops the grant immediately
    always_ff @(posedge rclk or posedge dirclr) begin
        if (dirclr) begin
            gnt_q   <= '0;
            sel_q   <= '0;
            rr_q    <= '0;
            word_q  <= '0;
            stall_q <= '0;
            done_q  <= 1'b0;
        end else begin
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            word_q  <= word_d;
            stall_q <= stall_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_afifo_read_sched.sv
// Bench for afifo_read_sched: the bench owns a queue-based FIFO and a
// burst-level reference model, and compares every output every cycle.
module tb_afifo_read_sched;

    localparam int W  = 12;
    localparam int NR = 4;
    localparam int BL = 8;
    localparam int SM = 16;

    logic          rclk = 1'b0;
    logic          dirclr;
    logic          fifo_r;
    logic [W-1:0]  fifo_rd;
    logic          fifo_rempty;
    logic [NR-1:0] req;
    logic [NR-1:0] gnt;
    logic [W-1:0]  dout;
    logic          dvalid;
    logic [NR-1:0] dready;
    logic          burst_done;
    logic          burst_short;

    afifo_read_sched #(.Width(W), .NReq(NR), .BurstLen(BL), .StallMax(SM)) dut (
        .rclk(rclk), .dirclr(dirclr), .fifo_r(fifo_r), .fifo_rd(fifo_rd),
        .fifo_rempty(fifo_rempty), .req(req), .gnt(gnt), .dout(dout),
        .dvalid(dvalid), .dready(dready), .burst_done(burst_done),
        .burst_short(burst_short)
    );

    always #5 rclk = ~rclk;

    int nvec = 0;
    int nerr = 0;

    // bench-side FIFO
    logic [W-1:0] fq[$];
    bit           hold_empty;
    int           fill_mode;      // 0 none, 1 keep topped up sequential, 2 random
    logic [W-1:0] fill_val;

    // reference model: who owns the port, and what is left of the burst
    int m_owner;                  // -1 when nobody holds a grant
    int m_end;                    // 0 none, 1 pending done pulse, 2 pending short pulse
    int m_words, m_stall, m_next;

    // observations of the DUT
    int           dut_pops, last_pops, n_done, n_short;
    logic [W-1:0] last_pop_data;
    logic [NR-1:0] prev_gnt;
    logic [NR-1:0] glog[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_rempty = hold_empty || (fq.size() == 0);
        fifo_rd     = (fq.size() != 0) ? fq[0] : '0;
    endtask

    // one clock: apply inputs, check at the falling edge, advance model and FIFO
    task automatic cyc(input logic [NR-1:0] r, input logic [NR-1:0] rd, input bit emp);
        logic [NR-1:0] e_gnt;
        bit e_dv, e_fr, e_done, e_short, emp_now, popped;
        int stall_before;
        req = r; dready = rd; hold_empty = emp;
        drive_fifo();
        @(negedge rclk);
        e_gnt = '0; e_dv = 0; e_fr = 0; e_done = 0; e_short = 0;
        emp_now = fifo_rempty;
        if (dirclr) begin
            m_owner = -1; m_end = 0; m_words = 0; m_stall = 0; m_next = 0;
        end else if (m_end != 0) begin
            e_done  = (m_end == 1);
            e_short = (m_end == 2);
            m_end   = 0;
            m_owner = -1;
        end else if (m_owner >= 0) begin
            e_gnt = 4'b0001 << m_owner;
            e_dv  = !emp_now;
            e_fr  = e_dv && dready[m_owner];
            if (e_dv) chk("dout", dout, fq[0]);
            stall_before = m_stall;
            if (e_fr) begin m_words++; m_stall = 0; end
            if (emp_now) m_stall = (m_stall >= 255) ? 255 : m_stall + 1;
            if (e_fr && m_words == BL)               m_end = 1;
            else if (!req[m_owner] && !e_fr)         m_end = 2;
            else if (emp_now && stall_before >= SM-1) m_end = 2;
        end else if (req != 0) begin
            for (int k = 0; k < NR; k++) begin
                int idx;
                idx = (m_next + k) % NR;
                if (m_owner < 0 && req[idx]) m_owner = idx;
            end
            m_next = (m_owner + 1) % NR; m_words = 0; m_stall = 0;
        end
        chk("gnt", gnt, e_gnt);
        chk("dvalid", dvalid, e_dv);
        chk("fifo_r", fifo_r, e_fr);
        chk("burst_done", burst_done, e_done);
        chk("burst_short", burst_short, e_short);
        popped = (fifo_r === 1'b1);
        if (popped) begin dut_pops++; last_pop_data = dout; end
        if (burst_done === 1'b1)  begin n_done++;  last_pops = dut_pops; dut_pops = 0; end
        if (burst_short === 1'b1) begin n_short++; last_pops = dut_pops; dut_pops = 0; end
        if (gnt != 0 && prev_gnt == 0) glog.push_back(gnt);
        prev_gnt = gnt;
        @(posedge rclk); #1;
        if (popped && fq.size() > 0) void'(fq.pop_front());
        if (fill_mode == 1) begin
            while (fq.size() < 4) begin fq.push_back(fill_val); fill_val++; end
        end else if (fill_mode == 2) begin
            if (fq.size() < 8 && $urandom_range(0, 3) != 0) fq.push_back(W'($urandom));
        end
        drive_fifo();
    endtask

    task automatic do_reset();
        dirclr = 1'b1;
        dut_pops = 0;
        cyc('0, '0, 1'b0);
        cyc('0, '0, 1'b0);
        dirclr = 1'b0;
        glog.delete(); last_pops = -1; n_done = 0; n_short = 0;
    endtask

    task automatic preload(input logic [W-1:0] base, input int n);
        fq.delete();
        for (int i = 0; i < n; i++) fq.push_back(base + W'(i));
        drive_fifo();
    endtask

    initial begin
        logic [NR-1:0] rq;
        dirclr = 1'b1; req = '0; dready = '0; hold_empty = 0; fill_mode = 0; fill_val = '0;
        m_owner = -1; m_end = 0; m_words = 0; m_stall = 0; m_next = 0;
        dut_pops = 0; last_pops = -1; n_done = 0; n_short = 0; prev_gnt = '0;
        last_pop_data = '0;
        preload(12'h000, 16);
        #1;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_fifo_r", fifo_r, 1'b0);
        do_reset();

        // single requester, full burst from a preloaded FIFO
        for (int i = 0; i < 9; i++) cyc(4'b0001, 4'b1111, 0);
        cyc(4'b0000, 4'b1111, 0);
        cyc(4'b0000, 4'b1111, 0);
        chk("t1_first_gnt", glog[0], 4'b0001);
        chk("t1_pops", last_pops, 8);
        chk("t1_last_data", last_pop_data, 12'h007);
        chk("t1_done_cnt", n_done, 1);

        // all four requesting, FIFO never empty
        do_reset();
        fill_mode = 1; fill_val = 12'h040; preload(12'h030, 4);
        for (int i = 0; i < 50; i++) cyc(4'b1111, 4'b1111, 0);
        chk("t2_ngrants", glog.size() >= 5, 1'b1);
        if (glog.size() >= 5) begin
            chk("t2_g0", glog[0], 4'b0001);
            chk("t2_g1", glog[1], 4'b0010);
            chk("t2_g2", glog[2], 4'b0100);
            chk("t2_g3", glog[3], 4'b1000);
            chk("t2_g4", glog[4], 4'b0001);
        end
        chk("t2_pops", last_pops, 8);

        // consumer 2 with dready alternating; other ready bits are noise
        do_reset();
        fill_mode = 0; preload(12'h100, 16);
        for (int i = 0; i < 17; i++)
            cyc(4'b0100, (NR'($urandom) & 4'b1011) | ((i % 2 == 1) ? 4'b0100 : 4'b0000), 0);
        cyc(4'b0000, 4'b0000, 0);
        chk("t3_pops", last_pops, 8);
        chk("t3_last_data", last_pop_data, 12'h107);
        chk("t3_done_cnt", n_done, 1);

        // FIFO runs dry after three words; stall timeout truncates the burst
        do_reset();
        preload(12'h200, 3);
        for (int i = 0; i < 23; i++) cyc(4'b0011, 4'b1111, 0);
        chk("t4_pops", last_pops, 3);
        chk("t4_short_cnt", n_short, 1);
        chk("t4_next_gnt", glog[glog.size()-1], 4'b0010);

        // req[1] drops after five pops on a non-pop cycle
        do_reset();
        preload(12'h300, 16);
        for (int i = 0; i < 6; i++) cyc(4'b0010, 4'b1111, 0);
        cyc(4'b0000, 4'b0000, 0);
        cyc(4'b0000, 4'b0000, 0);
        chk("t5_pops", last_pops, 5);
        chk("t5_short_cnt", n_short, 1);

        // req drop coinciding with a pop still delivers that word
        do_reset();
        preload(12'h400, 16);
        for (int i = 0; i < 4; i++) cyc(4'b0010, 4'b1111, 0);
        cyc(4'b0000, 4'b1111, 0);
        cyc(4'b0000, 4'b0000, 0);
        cyc(4'b0000, 4'b0000, 0);
        chk("t5b_pops", last_pops, 4);
        chk("t5b_last_data", last_pop_data, 12'h403);

        // reset asserted mid-burst after four pops
        do_reset();
        preload(12'h500, 16);
        for (int i = 0; i < 5; i++) cyc(4'b0001, 4'b1111, 0);
        chk("t6_pre_gnt", gnt, 4'b0001);
        dirclr = 1'b1;
        #1;
        chk("t6_async_gnt", gnt, 4'b0000);
        chk("t6_async_fifo_r", fifo_r, 1'b0);
        chk("t6_async_dvalid", dvalid, 1'b0);
        dut_pops = 0;
        cyc(4'b0001, 4'b1111, 0);
        dirclr = 1'b0;
        glog.delete(); n_done = 0; n_short = 0;
        for (int i = 0; i < 4; i++) cyc(4'b1011, 4'b1111, 0);
        chk("t6_after_gnt", glog[0], 4'b0001);
        chk("t6_no_pulse", n_done + n_short, 0);

        // randomized traffic with a dry spell in the middle
        do_reset();
        fq.delete();
        rq = 4'b0101;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) rq = NR'($urandom);
            fill_mode = (i >= 300 && i < 360) ? 0 : 2;
            cyc(rq, NR'($urandom), $urandom_range(0, 99) < 12);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
